// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps one request open to instruction memory and
// one fetched word buffered for the IF/ID register, with flush and drop on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        fetch_valid,
  output logic        if_id_write
);

  typedef enum logic [1:0] {REQ, FULL, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic [31:0] drop_addr_reg, drop_addr_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;

  // A full, stalled buffer has nowhere to put a new word, so no request goes out.
  always_comb begin
    imem_req    = reset && ((state_reg != FULL) || !stall);
    imem_addr   = (state_reg == DROP) ? drop_addr_reg : req_pc_reg;
    if_id_write = !stall || redirect;
    fetch_valid = reset && buf_valid_reg && !redirect;
    fetch_pc    = buf_pc_reg;
    fetch_instr = fetch_valid ? buf_instr_reg : NOP_INSTR;
  end

  always_comb begin
    state_next     = state_reg;
    req_pc_next    = req_pc_reg;
    drop_addr_next = drop_addr_reg;
    buf_valid_next = buf_valid_reg;
    buf_pc_next    = buf_pc_reg;
    buf_instr_next = buf_instr_reg;
    case (state_reg)
      REQ: begin
        if (redirect) begin
          req_pc_next = redirect_pc;
          if (!imem_ready) begin
            drop_addr_next = req_pc_reg;
            state_next     = DROP;
          end
        end else if (imem_ready) begin
          buf_valid_next = 1'b1;
          buf_pc_next    = req_pc_reg;
          buf_instr_next = imem_rdata;
          req_pc_next    = req_pc_reg + 32'd4;
          state_next     = FULL;
        end
      end
      FULL: begin
        if (redirect) begin
          buf_valid_next = 1'b0;
          req_pc_next    = redirect_pc;
          // Only a request actually issued and still unanswered must be drained.
          if (!stall && !imem_ready) begin
            drop_addr_next = req_pc_reg;
            state_next     = DROP;
          end else begin
            state_next = REQ;
          end
        end else if (!stall) begin
          if (imem_ready) begin
            buf_pc_next    = req_pc_reg;
            buf_instr_next = imem_rdata;
            req_pc_next    = req_pc_reg + 32'd4;
          end else begin
            buf_valid_next = 1'b0;
            state_next     = REQ;
          end
        end
      end
      DROP: begin
        if (redirect) req_pc_next = redirect_pc;
        if (imem_ready) state_next = REQ;
      end
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= REQ;
      req_pc_reg    <= RESET_PC;
      drop_addr_reg <= 32'h0;
      buf_valid_reg <= 1'b0;
      buf_pc_reg    <= 32'h0;
      buf_instr_reg <= NOP_INSTR;
    end else begin
      state_reg     <= state_next;
      req_pc_reg    <= req_pc_next;
      drop_addr_reg <= drop_addr_next;
      buf_valid_reg <= buf_valid_next;
      buf_pc_reg    <= buf_pc_next;
      buf_instr_reg <= buf_instr_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Random-stimulus bench for fetch_unit: expected instruction stream kept in a queue,
// a monitor pops and compares every word the IF/ID register accepts.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, stall, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, fetch_valid, if_id_write;
  logic [31:0] imem_addr, fetch_pc, fetch_instr;

  logic        w_req, w_valid, w_write;
  logic [31:0] w_addr, w_pc, w_instr;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .if_id_write(if_id_write)
  );

  // Second instance starting just below the top of the address space.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) wrap_dut (
    .clock(clock), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(32'h0), .fetch_pc(w_pc),
    .fetch_instr(w_instr), .fetch_valid(w_valid), .if_id_write(w_write)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          accepted = 0;
  logic        mem_zero_wait = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] next_fill;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_fill);
      next_fill = next_fill + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    next_fill = pc;
    refill();
  endtask

  // Instruction memory: answers a request either at once or after random waits.
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      #1;
      imem_ready = imem_req && (mem_zero_wait || ($urandom_range(0, 99) < 60));
      imem_rdata = imem_ready ? word_at(imem_addr) : $urandom;
    end
  end

  // Monitor: protocol, flush and reset rules every cycle; accepted words against the queue.
  initial begin
    logic        pending;
    logic [31:0] pending_addr;
    logic [31:0] exp_pc;
    int          idle;
    pending = 1'b0;
    pending_addr = 32'h0;
    idle = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        check("reset_imem_req", {31'h0, imem_req}, 32'h0);
        check("reset_fetch_valid", {31'h0, fetch_valid}, 32'h0);
        check("reset_fetch_instr", fetch_instr, NOP);
        pending = 1'b0;
        idle = 0;
      end else begin
        if (pending) begin
          check("held_imem_req", {31'h0, imem_req}, 32'h1);
          check("held_imem_addr", imem_addr, pending_addr);
        end
        check("if_id_write", {31'h0, if_id_write}, {31'h0, (!stall || redirect)});
        if (redirect) begin
          check("flush_fetch_valid", {31'h0, fetch_valid}, 32'h0);
          check("flush_fetch_instr", fetch_instr, NOP);
        end
        if (fetch_valid && if_id_write) begin
          if (exp_q.size() == 0) begin
            check("unexpected_fetch_pc", fetch_pc, 32'hFFFF_FFFF);
          end else begin
            exp_pc = exp_q.pop_front();
            check("fetch_pc", fetch_pc, exp_pc);
            check("fetch_instr", fetch_instr, word_at(exp_pc));
            $display("fetch pc=%h instr=%h", fetch_pc, fetch_instr);
          end
          accepted++;
          idle = 0;
        end else begin
          idle++;
        end
        if (idle > 100) begin
          check("fetch_progress_timeout", idle, 0);
          idle = 0;
        end
        pending = imem_req && !imem_ready;
        pending_addr = imem_addr;
      end
    end
  end

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    restart(32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Zero-wait stream straight out of reset.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clock);
      #3;
      check("stream_imem_addr", imem_addr, 32'(4 * k));
      if (k == 0) check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      if (k == 1) check("wrap_second_addr", w_addr, 32'h0000_0000);
      if (k > 0) begin
        check("stream_fetch_valid", {31'h0, fetch_valid}, 32'h1);
        check("stream_fetch_pc", fetch_pc, 32'(4 * (k - 1)));
      end
    end

    // Hold the buffered word for three stalled cycles, then release.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      stall = 1'b1;
      #3;
      check("stall_imem_req", {31'h0, imem_req}, 32'h0);
      check("stall_if_id_write", {31'h0, if_id_write}, 32'h0);
      check("stall_fetch_pc", fetch_pc, 32'h14);
    end
    @(negedge clock);
    stall = 1'b0;
    #3;
    check("release_fetch_pc", fetch_pc, 32'h14);
    check("release_imem_addr", imem_addr, 32'h18);

    // Redirect while stalled must still flush IF/ID.
    @(negedge clock);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    restart(32'h100);
    #3;
    check("redir_stall_if_id_write", {31'h0, if_id_write}, 32'h1);
    check("redir_stall_fetch_valid", {31'h0, fetch_valid}, 32'h0);
    check("redir_stall_fetch_instr", fetch_instr, NOP);

    // Random phase with wait states, stalls, redirects and one mid-run reset.
    mem_zero_wait = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      if (c == 700 || c == 701) begin
        reset = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        restart(32'h0);
      end else begin
        reset = 1'b1;
        stall = ($urandom_range(0, 99) < 25);
        redirect = ($urandom_range(0, 99) < 8);
        if (redirect) begin
          redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
          restart(redirect_pc);
        end else begin
          redirect_pc = $urandom;
          refill();
        end
      end
    end
    @(negedge clock);
    stall = 1'b0;
    redirect = 1'b0;
    repeat (3) @(negedge clock);
    #3;
    check("enough_fetches", {31'h0, (accepted > 200)}, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction word presented as a bubble.
REQ-003 Port: clock  input  1  sole clock; all state updates on posedge.
REQ-004 Port: reset  input  1  synchronous, active-low reset (0 sampled at posedge = reset).
REQ-005 Port: stall  input  1  hazard-unit hold request; 1 = IF/ID register holds.
REQ-006 Port: redirect  input  1  taken branch/jump; flushes fetch and retargets PC.
REQ-007 Port: redirect_pc  input  32  new fetch address, valid while redirect=1.
REQ-008 Port: imem_req  output  1  instruction-memory request.
REQ-009 Port: imem_addr  output  32  request address.
REQ-010 Port: imem_ready  input  1  imem_rdata valid; completes the current request.
REQ-011 Port: imem_rdata  input  32  instruction word.
REQ-012 Port: fetch_pc / fetch_instr / fetch_valid  output  32/32/1  IF/ID data_in fields.
REQ-013 Port: if_id_write  output  1  IF/ID register write enable.

Function
REQ-014 State SHALL be: FSM {REQ, FULL, DROP}; req_pc[31:0]; drop_addr[31:0]; one-entry buffer buf_valid, buf_pc, buf_instr.
REQ-015 Memory protocol: once imem_req=1 with imem_ready=0, imem_req SHALL stay 1 and imem_addr SHALL stay unchanged until the cycle imem_ready=1.
REQ-016 imem_req SHALL be 1 in REQ and DROP, 1 in FULL only when stall=0, and 0 while reset=0.
REQ-017 imem_addr SHALL be drop_addr in DROP, otherwise req_pc.
REQ-018 if_id_write SHALL equal (!stall || redirect); redirect overrides stall so IF/ID captures the flush.
REQ-019 fetch_valid SHALL equal buf_valid && !redirect; fetch_pc = buf_pc; fetch_instr = buf_instr when fetch_valid=1, else NOP_INSTR.
REQ-020 REQ, imem_ready=1, redirect=0: SHALL load buffer {req_pc, imem_rdata}, set req_pc += 4, and go to FULL.
REQ-021 REQ, imem_ready=1, redirect=1: SHALL discard the response, set req_pc = redirect_pc, and stay in REQ.
REQ-022 REQ, imem_ready=0, redirect=1: SHALL set drop_addr = req_pc and req_pc = redirect_pc, and go to DROP.
REQ-023 FULL, stall=1, redirect=0: SHALL hold all state, with no request issued.
REQ-024 FULL, stall=0, redirect=0: buffer drains; imem_ready=1 reloads the buffer, sets req_pc += 4 and stays in FULL (1 instr/cycle); imem_ready=0 clears buf_valid and goes to REQ with the request outstanding.
REQ-025 FULL, redirect=1: SHALL clear buf_valid and set req_pc = redirect_pc; go to DROP (drop_addr = old req_pc) if a request was issued and imem_ready=0, else go to REQ.
REQ-026 DROP: imem_ready=1 SHALL discard the response and go to REQ; redirect=1 in DROP SHALL update req_pc = redirect_pc and not change drop_addr.
REQ-027 Arithmetic: req_pc + 4 SHALL be 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 A discarded or dropped response SHALL never appear with fetch_valid=1.

Reset
REQ-029 reset=0 at posedge SHALL set: state = REQ, req_pc = RESET_PC, drop_addr = 0, buf_valid = 0, buf_pc = 0, buf_instr = NOP_INSTR.
REQ-030 Reset mid-request SHALL abandon the outstanding request; instruction memory is reset on the same reset.
REQ-031 During reset: fetch_valid = 0, fetch_instr = NOP_INSTR, and imem_req = 0.

Verification
REQ-032 Reset release with zero-wait memory returning 0xA0+addr: imem_addr = 0,4,8,... and fetch_valid=1 every cycle from cycle 2, with fetch_pc = 0,4,8.
REQ-033 stall=1 for 3 cycles with buffer {pc 8}: fetch_pc = 8 held, imem_req = 0, if_id_write = 0; release resumes at pc 12.
REQ-034 redirect to 0x100 with imem_ready=0 at addr 0x10, ready 2 cycles later: imem_addr stays 0x10 until ready, that word is dropped, next request is 0x100, and the first valid fetch_pc is 0x100.
REQ-035 redirect=1 together with stall=1 while FULL: if_id_write = 1, fetch_valid = 0, fetch_instr = 0x13.
REQ-036 Second redirect (0x200) while in DROP from a first redirect (0x100): 0x100 is never requested, and the first valid fetch_pc is 0x200.
REQ-037 RESET_PC = 0xFFFF_FFFC: the second request address is 0x0000_0000.
